// File: rtl/xrv_pkg.sv
// Shared RV32 decode definitions: opcode constants, immediate formats and the
// decoded-entry bundle passed from decode to execute.
package xrv_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  // M-extension shares the OP_REG opcode; funct7 tells them apart.
  localparam logic [6:0] OP_MULT_DIV   = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic        op_lui;
    logic        op_auipc;
    logic        op_jal;
    logic        op_jalr;
    logic        op_branch;
    logic        op_load;
    logic        op_store;
    logic        op_imm;
    logic        op_reg;
    logic        op_muldiv;
    logic        op_illegal;
    logic        compressed;
    logic [31:0] imm;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dest;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic [31:0] pc_link;
    logic [31:0] pc_target;
  } id_entry_t;

  function automatic logic [31:0] decode_imm(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'h000};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/xrv_id_q_if.sv
// Fetch-side and execute-side signals of the decode queue.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both
// high; a producer holds valid and its payload stable until that edge.
interface xrv_id_q_if;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;
  logic        inst_valid;
  logic        inst_ready;
  logic        id_jmp;
  logic [31:0] id_jmp_addr;
  logic        ex_valid;
  logic        ex_ready;
  logic        op_lui;
  logic        op_auipc;
  logic        op_jal;
  logic        op_jalr;
  logic        op_branch;
  logic        op_load;
  logic        op_store;
  logic        op_imm;
  logic        op_reg;
  logic        op_muldiv;
  logic        op_illegal;
  logic        op_is_compressed;
  logic [31:0] imm_signed;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [4:0]  dest;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] ex_pc;
  logic [31:0] ex_pc_link;
  logic [31:0] ex_pc_target;

  modport master (
    output inst, inst_pc, inst_is_compressed, inst_valid, ex_ready,
    input  inst_ready, id_jmp, id_jmp_addr, ex_valid,
    input  op_lui, op_auipc, op_jal, op_jalr, op_branch, op_load, op_store,
    input  op_imm, op_reg, op_muldiv, op_illegal, op_is_compressed,
    input  imm_signed, src1, src2, dest, funct3, funct7,
    input  ex_pc, ex_pc_link, ex_pc_target
  );

  modport slave (
    input  inst, inst_pc, inst_is_compressed, inst_valid, ex_ready,
    output inst_ready, id_jmp, id_jmp_addr, ex_valid,
    output op_lui, op_auipc, op_jal, op_jalr, op_branch, op_load, op_store,
    output op_imm, op_reg, op_muldiv, op_illegal, op_is_compressed,
    output imm_signed, src1, src2, dest, funct3, funct7,
    output ex_pc, ex_pc_link, ex_pc_target
  );
endinterface

// File: rtl/xrv_id_fifo.sv
// Generic DEPTH-entry queue of decoded entries with a synchronous clear.
// Caller guarantees push only when not full (or popping) and pop only when not empty.
module xrv_id_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [31:0]
) (
    input  logic   clk,
    input  logic   rstb,
    input  logic   clr,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NSLOT = 1 << PW;
    localparam int CW    = $clog2(DEPTH + 1);

    entry_t          mem [NSLOT];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Explicit wrap keeps DEPTH=1 on slot 0; powers of two wrap naturally anyway.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < NSLOT; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xrv_id_q.sv
// RV32 decode stage: decodes one instruction per cycle into id_entry_t, queues
// entries for execute, and issues an early redirect for JAL.
module xrv_id_q
    import xrv_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int EN_MULDIV = 1,
    parameter int EARLY_JAL = 1
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       flush,
    xrv_id_q_if.slave  bus
);

    id_entry_t dec;
    id_entry_t head;
    imm_fmt_e  fmt;
    logic      push;
    logic      pop;
    logic      full;
    logic      empty;

    always_comb begin
        dec = '0;
        fmt = IMM_NONE;
        case (bus.inst[6:0])
            OP_LUI:    begin dec.op_lui    = 1'b1; fmt = IMM_U; end
            OP_AUIPC:  begin dec.op_auipc  = 1'b1; fmt = IMM_U; end
            OP_JAL:    begin dec.op_jal    = 1'b1; fmt = IMM_J; end
            OP_JALR:   begin dec.op_jalr   = 1'b1; fmt = IMM_I; end
            OP_BRANCH: begin dec.op_branch = 1'b1; fmt = IMM_B; end
            OP_LOAD:   begin dec.op_load   = 1'b1; fmt = IMM_I; end
            OP_STORE:  begin dec.op_store  = 1'b1; fmt = IMM_S; end
            OP_IMM:    begin dec.op_imm    = 1'b1; fmt = IMM_I; end
            OP_REG: begin
                if (bus.inst[31:25] == FUNCT7_MULDIV) begin
                    if (EN_MULDIV != 0) dec.op_muldiv  = 1'b1;
                    else                dec.op_illegal = 1'b1;
                end else begin
                    dec.op_reg = 1'b1;
                end
            end
            // Every known opcode ends in 2'b11, so 16-bit encodings land here too.
            default:   dec.op_illegal = 1'b1;
        endcase
        dec.compressed = bus.inst_is_compressed;
        dec.imm        = decode_imm(bus.inst, fmt);
        dec.src1       = bus.inst[19:15];
        dec.src2       = bus.inst[24:20];
        dec.dest       = bus.inst[11:7];
        dec.funct3     = bus.inst[14:12];
        dec.funct7     = bus.inst[31:25];
        dec.pc         = bus.inst_pc;
        dec.pc_link    = bus.inst_pc + (bus.inst_is_compressed ? 32'd2 : 32'd4);
        dec.pc_target  = bus.inst_pc + dec.imm;
    end

    // inst_ready looks through ex_ready so a full queue still streams at 1/cycle.
    assign bus.inst_ready = ~full | bus.ex_ready;
    assign push           = bus.inst_valid & bus.inst_ready & ~flush;
    assign pop            = ~empty & bus.ex_ready & ~flush;

    assign bus.id_jmp      = (EARLY_JAL != 0) & push & dec.op_jal;
    assign bus.id_jmp_addr = bus.inst_pc + decode_imm(bus.inst, IMM_J);

    xrv_id_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (id_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .wdata (dec),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.ex_valid         = ~empty;
    assign bus.op_lui           = head.op_lui;
    assign bus.op_auipc         = head.op_auipc;
    assign bus.op_jal           = head.op_jal;
    assign bus.op_jalr          = head.op_jalr;
    assign bus.op_branch        = head.op_branch;
    assign bus.op_load          = head.op_load;
    assign bus.op_store         = head.op_store;
    assign bus.op_imm           = head.op_imm;
    assign bus.op_reg           = head.op_reg;
    assign bus.op_muldiv        = head.op_muldiv;
    assign bus.op_illegal       = head.op_illegal;
    assign bus.op_is_compressed = head.compressed;
    assign bus.imm_signed       = head.imm;
    assign bus.src1             = head.src1;
    assign bus.src2             = head.src2;
    assign bus.dest             = head.dest;
    assign bus.funct3           = head.funct3;
    assign bus.funct7           = head.funct7;
    assign bus.ex_pc            = head.pc;
    assign bus.ex_pc_link       = head.pc_link;
    assign bus.ex_pc_target     = head.pc_target;

endmodule
